// File: rtl/gray_tree_seq_if.sv
// Frame-event handshake between the gray tree sequencer and the sample readout.
//   frame_valid  sequencer -> readout  a frame event is pending
//   frame_ready  readout -> sequencer  readout takes the pending event
//   frame_idx    sequencer -> readout  index of the pending frame
interface gray_tree_seq_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_idx;

  modport master (output frame_valid, output frame_idx, input frame_ready);
  modport slave  (input frame_valid, input frame_idx, output frame_ready);
endinterface

// File: rtl/gray_tree_seq.sv
// Sequencer for the gray-code clock-divider tree feeding the cochlea sine
// generators. Holds the tree in reset, releases it, paces it with a
// qualified advance pulse, tracks the gray position and reports every
// completed gray period (frame) over a valid/ready handshake.
//
// Ports
//   clk_master  master clock, everything on its rising edge
//   rst         synchronous active-high reset
//   start       begin request, honoured in IDLE only
//   stop        end request, honoured in RUN; finishes the current frame
//   cfg_stages  active stage count (0 -> 1, above MAX_STAGES -> MAX_STAGES)
//   cfg_div     one advance every cfg_div+1 cycles
//   tree_rstb   active-low reset to the tree (low in IDLE and HOLD)
//   tree_adv    one-cycle advance qualifier
//   gray_pos    gray code of the current position
//   overrun     sticky: a frame event arrived while one was still pending
//   busy        high in every state except IDLE
//   frm         frame-event handshake (master side)
module gray_tree_seq #(
  parameter int MAX_STAGES = 10,
  parameter int RST_HOLD   = 4
) (
  input  logic                  clk_master,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [3:0]            cfg_stages,
  input  logic [7:0]            cfg_div,
  output logic                  tree_rstb,
  output logic                  tree_adv,
  output logic [MAX_STAGES-1:0] gray_pos,
  output logic                  overrun,
  output logic                  busy,
  gray_tree_seq_if.master       frm
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DRAIN} state_t;

  function automatic logic [3:0] clamp_stages(input logic [3:0] s);
    logic [3:0] r;
    if (s == 4'd0)                 r = 4'd1;
    else if (int'(s) > MAX_STAGES) r = 4'(MAX_STAGES);
    else                           r = s;
    return r;
  endfunction

  // Position mask: ones on the active stages, so the wrap point is pos == mask
  // and the gray bits above the active stage count can never be set.
  function automatic logic [MAX_STAGES-1:0] stage_mask(input logic [3:0] s);
    logic [MAX_STAGES-1:0] m;
    for (int i = 0; i < MAX_STAGES; i++) m[i] = (i < int'(s));
    return m;
  endfunction

  function automatic logic [MAX_STAGES-1:0] bin2gray(input logic [MAX_STAGES-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t                state, state_n;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_n;
  logic [7:0]            div_l, div_cnt, div_cnt_n;
  logic [MAX_STAGES-1:0] mask_l, pos, pos_n;
  logic [15:0]           frame_cnt;
  logic                  accept, wrap, run_n, adv_n, frame_evt, hs;

  assign accept    = (state == IDLE) && start;
  assign wrap      = (pos == mask_l);
  // tree_adv is only ever high in RUN/DRAIN, on the cycle the divider hits div_l.
  assign frame_evt = tree_adv && wrap;
  assign hs        = frm.frame_valid && frm.frame_ready;

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    div_cnt_n  = div_cnt;
    pos_n      = pos;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
          div_cnt_n  = '0;
          pos_n      = '0;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n   = RUN;
          div_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      RUN, DRAIN: begin
        if (tree_adv) begin
          div_cnt_n = '0;
          pos_n     = wrap ? '0 : pos + MAX_STAGES'(1);
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
        // A wrap ends the run when draining, or when stop lands on the wrap itself.
        if (frame_evt && ((state == DRAIN) || stop)) state_n = IDLE;
        else if ((state == RUN) && stop)             state_n = DRAIN;
      end
      default: state_n = IDLE;
    endcase
    run_n = (state_n == RUN) || (state_n == DRAIN);
    adv_n = run_n && (div_cnt_n == div_l);
  end

  // Control register stage: FSM, counters and registered tree outputs
  always_ff @(posedge clk_master) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      div_cnt   <= '0;
      pos       <= '0;
      tree_rstb <= 1'b0;
      tree_adv  <= 1'b0;
      gray_pos  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_cnt_n;
      div_cnt   <= div_cnt_n;
      pos       <= pos_n;
      tree_rstb <= run_n;
      tree_adv  <= adv_n;
      gray_pos  <= bin2gray(pos_n);
      busy      <= (state_n != IDLE);
    end
  end

  // Configuration latch stage
  always_ff @(posedge clk_master) begin
    if (accept) begin
      div_l  <= cfg_div;
      mask_l <= stage_mask(clamp_stages(cfg_stages));
    end
  end

  // Frame event stage: pending event, index, overrun
  always_ff @(posedge clk_master) begin
    if (rst) begin
      frm.frame_valid <= 1'b0;
      frm.frame_idx   <= '0;
      overrun         <= 1'b0;
      frame_cnt       <= '0;
    end else if (accept) begin
      frm.frame_valid <= 1'b0;
      overrun         <= 1'b0;
      frame_cnt       <= '0;
    end else if (frame_evt) begin
      // The counter always moves, so dropped frames show up as an index gap.
      if (!frm.frame_valid || hs) begin
        frm.frame_valid <= 1'b1;
        frm.frame_idx   <= frame_cnt;
      end else begin
        overrun <= 1'b1;
      end
      frame_cnt <= frame_cnt + 16'd1;
    end else if (hs) begin
      frm.frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_tree_seq.sv
// Bench for gray_tree_seq: frame indices are queued when a run is started and
// popped by a monitor whenever a handshake completes; timing and state are
// checked directly against cycle counts derived from the configuration.
module tb_gray_tree_seq;
  localparam int MAX_STAGES = 10;
  localparam int RST_HOLD   = 4;

  logic                  clk_master = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic [3:0]            cfg_stages = 4'd0;
  logic [7:0]            cfg_div = 8'd0;
  logic                  tree_rstb, tree_adv, overrun, busy;
  logic [MAX_STAGES-1:0] gray_pos;

  gray_tree_seq_if fif ();

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] sb[$];

  always #5 clk_master = ~clk_master;

  gray_tree_seq #(.MAX_STAGES(MAX_STAGES), .RST_HOLD(RST_HOLD)) dut (
    .clk_master (clk_master),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_stages (cfg_stages),
    .cfg_div    (cfg_div),
    .tree_rstb  (tree_rstb),
    .tree_adv   (tree_adv),
    .gray_pos   (gray_pos),
    .overrun    (overrun),
    .busy       (busy),
    .frm        (fif.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A handshake completes at the next rising edge when valid & ready are seen here.
  always @(negedge clk_master) begin
    if (!rst && fif.frame_valid && fif.frame_ready) begin
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("sb_frame_idx", 32'(fif.frame_idx), 32'(sb.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_master);
    #1;
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    rst = 1'b1; start = 1'b0; stop = 1'b0; fif.frame_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rstb"},  32'(tree_rstb),       32'd0);
    chk({tag, "_adv"},   32'(tree_adv),        32'd0);
    chk({tag, "_gray"},  32'(gray_pos),        32'd0);
    chk({tag, "_valid"}, 32'(fif.frame_valid), 32'd0);
    chk({tag, "_idx"},   32'(fif.frame_idx),   32'd0);
    chk({tag, "_ovr"},   32'(overrun),         32'd0);
    chk({tag, "_busy"},  32'(busy),            32'd0);
  endtask

  task automatic do_start(input logic [3:0] s, input logic [7:0] d);
    cfg_stages = s; cfg_div = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts cycles with tree_rstb low; returns at the first RUN cycle.
  task automatic wait_run(input string tag, input int exp_low);
    int n;
    n = 0;
    while (!tree_rstb && n < 64) begin
      n++;
      step();
    end
    chk({tag, "_hold"}, 32'(n), 32'(exp_low));
  endtask

  task automatic frame_len(input string tag, input int exp_len);
    int n;
    n = 0;
    while (!fif.frame_valid && n < 2000) begin
      n++;
      step();
    end
    chk({tag, "_len"}, 32'(n), 32'(exp_len));
  endtask

  initial begin
    int n_adv;
    fif.frame_ready = 1'b0;
    step();
    step();
    check_reset_vals("reset");

    // stages=3, div=0: advance every cycle, gray 0,1,3,2,6,7,5,4,0
    do_reset();
    sb.push_back(16'h0000);
    do_start(4'd3, 8'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_run("t1", RST_HOLD);
    for (int i = 0; i <= 8; i++) begin
      chk("t1_adv",   32'(tree_adv), 32'd1);
      chk("t1_gray",  32'(gray_pos), 32'((i % 8) ^ ((i % 8) >> 1)));
      chk("t1_valid", 32'(fif.frame_valid), 32'(i == 8));
      if (i < 8) step();
    end
    fif.frame_ready = 1'b1;
    step();
    fif.frame_ready = 1'b0;

    // stages=2, div=2, ready high: advance every 3 cycles, frame every 12
    do_reset();
    for (int j = 0; j < 3; j++) sb.push_back(16'(j));
    fif.frame_ready = 1'b1;
    do_start(4'd2, 8'd2);
    wait_run("t2", RST_HOLD);
    for (int k = 0; k <= 36; k++) begin
      if (k < 36) chk("t2_adv", 32'(tree_adv), 32'(k % 3 == 2));
      chk("t2_valid", 32'(fif.frame_valid), 32'(k > 0 && k % 12 == 0));
      step();
    end
    fif.frame_ready = 1'b0;

    // stages=1, div=0, ready low for 10 cycles: overrun, index gap
    do_reset();
    sb.push_back(16'd0);
    sb.push_back(16'd5);
    do_start(4'd1, 8'd0);
    wait_run("t3", RST_HOLD);
    for (int k = 0; k <= 13; k++) begin
      fif.frame_ready = (k >= 10 && k <= 12);
      if (k == 2) chk("t3_no_overrun", 32'(overrun), 32'd0);
      if (k == 9) begin
        chk("t3_overrun",  32'(overrun),       32'd1);
        chk("t3_idx_held", 32'(fif.frame_idx), 32'd0);
      end
      step();
    end
    fif.frame_ready = 1'b0;
    chk("t3_overrun_sticky", 32'(overrun), 32'd1);

    // stop at position 5 (stages=3): three more advances, event, IDLE
    do_reset();
    sb.push_back(16'd0);
    do_start(4'd3, 8'd0);
    wait_run("t4", RST_HOLD);
    n_adv = 0;
    for (int k = 0; k <= 9; k++) begin
      stop = (k == 5);
      fif.frame_ready = (k == 9);
      if (k == 5) chk("t4_pos5", 32'(gray_pos), 32'd7);
      if (k >= 5 && tree_adv) n_adv++;
      if (k == 6) chk("t4_drain_busy", 32'(busy), 32'd1);
      if (k == 8) begin
        chk("t4_idle_busy", 32'(busy),            32'd0);
        chk("t4_idle_rstb", 32'(tree_rstb),       32'd0);
        chk("t4_idle_adv",  32'(tree_adv),        32'd0);
        chk("t4_valid",     32'(fif.frame_valid), 32'd1);
      end
      step();
    end
    stop = 1'b0;
    fif.frame_ready = 1'b0;
    chk("t4_adv_after_stop", 32'(n_adv), 32'd3);

    // stop on the wrap cycle (stages=2, pos 3): straight to IDLE, event pends
    do_start(4'd2, 8'd0);
    wait_run("t4b", RST_HOLD);
    for (int k = 0; k <= 3; k++) begin
      stop = (k == 3);
      step();
    end
    stop = 1'b0;
    chk("t4b_busy",  32'(busy),            32'd0);
    chk("t4b_adv",   32'(tree_adv),        32'd0);
    chk("t4b_valid", 32'(fif.frame_valid), 32'd1);
    chk("t4b_idx",   32'(fif.frame_idx),   32'd0);
    step(); step(); step();
    chk("t4b_pending_idle", 32'(fif.frame_valid), 32'd1);

    // stages=0 clamps to 1: 2-advance frame; start clears the pending event
    do_start(4'd0, 8'd0);
    chk("t5_start_clears", 32'(fif.frame_valid), 32'd0);
    wait_run("t5a", RST_HOLD);
    frame_len("t5a", 2);

    // stages=15 clamps to 10: 1024-advance frame
    do_reset();
    do_start(4'd15, 8'd0);
    wait_run("t5b", RST_HOLD);
    frame_len("t5b", 1024);

    // frame_idx wraps 0xFFFF -> 0 (counter preloaded during HOLD)
    do_reset();
    sb.push_back(16'hFFFE);
    sb.push_back(16'hFFFF);
    sb.push_back(16'h0000);
    fif.frame_ready = 1'b1;
    do_start(4'd1, 8'd0);
    force dut.frame_cnt = 16'hFFFE;
    step();
    release dut.frame_cnt;
    wait_run("t5w", RST_HOLD - 1);
    for (int k = 0; k <= 6; k++) step();
    fif.frame_ready = 1'b0;

    // rst during HOLD with start/stop asserted alongside
    do_reset();
    do_start(4'd3, 8'd0);
    step();
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    step();
    check_reset_vals("t6a");
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    chk("t6a_stays_idle", 32'(busy), 32'd0);

    // rst during RUN with an event pending
    do_start(4'd1, 8'd0);
    wait_run("t6b", RST_HOLD);
    step(); step(); step();
    chk("t6b_pre_valid", 32'(fif.frame_valid), 32'd1);
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    step();
    check_reset_vals("t6b");
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    chk("t6b_stays_idle", 32'(busy), 32'd0);

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
